// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, writeback ports, issue/flush control
// and the scoreboard status returned to decode.
interface regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2
);
   localparam int AW = $clog2(NREG);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD-1:0]      rd_used;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_pend;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic                flush;
   logic                hazard;
   logic [AW:0]         pend_cnt;

   modport master (
      output rd_addr, rd_used, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
      input  rd_data, rd_pend, hazard, pend_cnt
   );

   modport slave (
      input  rd_addr, rd_used, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
      output rd_data, rd_pend, hazard, pend_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised integer register file with multi-port writeback, same-cycle
// write-to-read bypass and a pending-write scoreboard driving the decode stall.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2
) (
   input logic          clk_cpu,
   input logic          rst_cpu_n,
   regfile_sb_if.slave  bus
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] pend_q, pend_d;
   logic [AW:0]     pend_cnt_q, pend_cnt_d;
   logic [NREG-1:0] wr_hit;
   logic            waw;

   // regs_d already holds the highest-port value for any register written this
   // cycle, so it doubles as the bypassed read source.
   always_comb begin
      regs_d = regs_q;
      wr_hit = '0;
      for (int j = 0; j < NWR; j++) begin
         if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != '0)) begin
            wr_hit[bus.wr_addr[j*AW +: AW]] = 1'b1;
            regs_d[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
         end
      end
      regs_d[0] = '0;
   end

   always_comb begin
      pend_d = pend_q & ~wr_hit;
      if (bus.iss_valid && (bus.iss_rd != '0)) begin
         pend_d[bus.iss_rd] = 1'b1;
      end
      if (bus.flush) begin
         pend_d = '0;
      end
      pend_d[0] = 1'b0;
      pend_cnt_d = '0;
      for (int i = 0; i < NREG; i++) begin
         pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[i]};
      end
   end

   always_comb begin
      bus.rd_data = '0;
      bus.rd_pend = '0;
      for (int k = 0; k < NRD; k++) begin
         if (rst_cpu_n) begin
            bus.rd_data[k*XLEN +: XLEN] = regs_d[bus.rd_addr[k*AW +: AW]];
         end
         bus.rd_pend[k] = pend_q[bus.rd_addr[k*AW +: AW]] & ~wr_hit[bus.rd_addr[k*AW +: AW]];
      end
      waw = bus.iss_valid && (bus.iss_rd != '0) && pend_q[bus.iss_rd] && !wr_hit[bus.iss_rd];
      bus.hazard = (|(bus.rd_used & bus.rd_pend)) | waw;
   end

   assign bus.pend_cnt = pend_cnt_q;

   always_ff @(posedge clk_cpu or negedge rst_cpu_n) begin
      if (!rst_cpu_n) begin
         regs_q     <= '{default: '0};
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: an architectural model checked every cycle
// plus literal expectations for the bypass, scoreboard and reset scenarios.
module tb_regfile_sb;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int AW   = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   logic [XLEN-1:0] model_regs [NREG] = '{default: '0};
   bit              model_pend [NREG] = '{default: 1'b0};
   int              model_cnt = 0;
   bit              p_next;
   int              cnt_next;
   logic [AW-1:0]   cmp_a;
   bit              exp_pend [NRD];
   bit              exp_haz;

   regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
      .clk_cpu   (clk),
      .rst_cpu_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit w_hit(input logic [AW-1:0] a);
      for (int j = 0; j < NWR; j++) begin
         if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Highest-numbered writer to a wins; otherwise the architectural value.
   function automatic logic [31:0] m_bypass(input logic [AW-1:0] a);
      for (int j = NWR - 1; j >= 0; j--) begin
         if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a) return bus.wr_data[j*XLEN +: XLEN];
      end
      return model_regs[a];
   endfunction

   function automatic logic [31:0] m_read(input logic [AW-1:0] a);
      if (!rst_n || a == '0) return '0;
      return m_bypass(a);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            model_regs[r] <= '0;
            model_pend[r] <= 1'b0;
         end
         model_cnt <= 0;
      end else begin
         cnt_next = 0;
         for (int r = 1; r < NREG; r++) begin
            p_next = model_pend[r];
            if (w_hit(AW'(r))) begin
               model_regs[r] <= m_bypass(AW'(r));
               p_next = 1'b0;
            end
            if (bus.iss_valid && bus.iss_rd == AW'(r)) p_next = 1'b1;
            if (bus.flush) p_next = 1'b0;
            model_pend[r] <= p_next;
            if (p_next) cnt_next++;
         end
         model_cnt <= cnt_next;
      end
   end

   always @(negedge clk) begin
      exp_haz = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         cmp_a = bus.rd_addr[k*AW +: AW];
         exp_pend[k] = rst_n && cmp_a != '0 && model_pend[cmp_a] && !w_hit(cmp_a);
         if (bus.rd_used[k] && exp_pend[k]) exp_haz = 1'b1;
         check_output($sformatf("model rd_data[%0d]", k), bus.rd_data[k*XLEN +: XLEN], m_read(cmp_a));
         check_output($sformatf("model rd_pend[%0d]", k), 32'(bus.rd_pend[k]), 32'(exp_pend[k]));
      end
      if (rst_n && bus.iss_valid && bus.iss_rd != '0 && model_pend[bus.iss_rd] && !w_hit(bus.iss_rd))
         exp_haz = 1'b1;
      check_output("model hazard", 32'(bus.hazard), 32'(exp_haz));
      check_output("model pend_cnt", 32'(bus.pend_cnt), 32'(model_cnt));
   end

   task automatic set_idle();
      bus.rd_addr   = '0;
      bus.rd_used   = '0;
      bus.wr_en     = '0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.iss_valid = 1'b0;
      bus.iss_rd    = '0;
      bus.flush     = 1'b0;
   endtask

   task automatic set_rd(input int k, input int a, input bit used);
      bus.rd_addr[k*AW +: AW] = AW'(a);
      bus.rd_used[k]          = used;
   endtask

   task automatic set_wr(input int j, input int a, input logic [31:0] d);
      bus.wr_en[j]              = 1'b1;
      bus.wr_addr[j*AW +: AW]   = AW'(a);
      bus.wr_data[j*XLEN +: XLEN] = d;
   endtask

   task automatic set_iss(input int a);
      bus.iss_valid = 1'b1;
      bus.iss_rd    = AW'(a);
   endtask

   task automatic apply_stimulus();
      @(negedge clk);
      #1;
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
      set_idle();
   endtask

   function automatic logic [31:0] rd(input int k);
      return bus.rd_data[k*XLEN +: XLEN];
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      set_idle();
      set_rd(0, 5, 1'b1);
      set_wr(0, 5, 32'h1234_5678);
      apply_stimulus();
      check_output("in-reset rd_data", rd(0), 32'h0);
      check_output("in-reset hazard", 32'(bus.hazard), 32'h0);
      next_edge();
      rst_n = 1'b1;

      for (int a = 0; a < NREG; a++) begin
         set_rd(0, a, 1'b1);
         set_rd(1, NREG - 1 - a, 1'b1);
         apply_stimulus();
         check_output("post-reset rd_data[0]", rd(0), 32'h0);
         check_output("post-reset rd_data[1]", rd(1), 32'h0);
         check_output("post-reset pend_cnt", 32'(bus.pend_cnt), 32'h0);
         next_edge();
      end

      set_wr(0, 5, 32'hDEAD_BEEF);
      set_rd(0, 5, 1'b0);
      apply_stimulus();
      check_output("bypass x5", rd(0), 32'hDEAD_BEEF);
      next_edge();
      set_rd(0, 5, 1'b0);
      apply_stimulus();
      check_output("stored x5", rd(0), 32'hDEAD_BEEF);
      next_edge();

      set_wr(0, 7, 32'h11);
      set_wr(1, 7, 32'h22);
      set_rd(0, 7, 1'b0);
      set_rd(1, 7, 1'b0);
      apply_stimulus();
      check_output("dual write bypass p0", rd(0), 32'h22);
      check_output("dual write bypass p1", rd(1), 32'h22);
      next_edge();
      set_wr(1, 0, 32'hFFFF_FFFF);
      set_rd(0, 0, 1'b0);
      set_rd(1, 7, 1'b0);
      apply_stimulus();
      check_output("x0 write bypass", rd(0), 32'h0);
      check_output("dual write stored x7", rd(1), 32'h22);
      next_edge();
      set_rd(0, 0, 1'b0);
      apply_stimulus();
      check_output("x0 stored", rd(0), 32'h0);
      next_edge();

      set_iss(3);
      apply_stimulus();
      check_output("first issue x3 hazard", 32'(bus.hazard), 32'h0);
      next_edge();
      set_rd(0, 3, 1'b1);
      apply_stimulus();
      check_output("x3 pend_cnt", 32'(bus.pend_cnt), 32'd1);
      check_output("x3 RAW hazard", 32'(bus.hazard), 32'h1);
      check_output("x3 rd_pend", 32'(bus.rd_pend[0]), 32'h1);
      next_edge();
      set_rd(0, 3, 1'b1);
      set_wr(0, 3, 32'h40);
      apply_stimulus();
      check_output("x3 wb rd_pend", 32'(bus.rd_pend[0]), 32'h0);
      check_output("x3 wb hazard", 32'(bus.hazard), 32'h0);
      check_output("x3 wb rd_data", rd(0), 32'h40);
      next_edge();
      apply_stimulus();
      check_output("x3 cleared pend_cnt", 32'(bus.pend_cnt), 32'd0);
      next_edge();

      set_iss(9);
      next_edge();
      set_wr(1, 9, 32'h99);
      set_iss(9);
      apply_stimulus();
      check_output("x9 set+clear hazard", 32'(bus.hazard), 32'h0);
      next_edge();
      set_rd(0, 9, 1'b0);
      apply_stimulus();
      check_output("x9 set beats clear cnt", 32'(bus.pend_cnt), 32'd1);
      check_output("x9 still pending", 32'(bus.rd_pend[0]), 32'h1);
      next_edge();
      set_iss(9);
      apply_stimulus();
      check_output("x9 WAW hazard", 32'(bus.hazard), 32'h1);
      next_edge();
      apply_stimulus();
      check_output("x9 re-set no double count", 32'(bus.pend_cnt), 32'd1);

      next_edge();
      set_iss(1);
      next_edge();
      set_iss(2);
      next_edge();
      set_iss(4);
      apply_stimulus();
      check_output("three pending cnt", 32'(bus.pend_cnt), 32'd3);
      next_edge();
      bus.flush = 1'b1;
      set_iss(6);
      set_wr(0, 10, 32'h1234);
      apply_stimulus();
      check_output("pre-flush cnt", 32'(bus.pend_cnt), 32'd4);
      next_edge();
      set_rd(0, 10, 1'b0);
      set_rd(1, 6, 1'b1);
      apply_stimulus();
      check_output("post-flush cnt", 32'(bus.pend_cnt), 32'd0);
      check_output("write during flush", rd(0), 32'h1234);
      check_output("post-flush hazard", 32'(bus.hazard), 32'h0);
      next_edge();

      set_wr(0, 12, 32'hABCD);
      set_rd(0, 5, 1'b1);
      set_rd(1, 12, 1'b1);
      apply_stimulus();
      check_output("pre-reset x5", rd(0), 32'hDEAD_BEEF);
      check_output("pre-reset bypass x12", rd(1), 32'hABCD);
      rst_n = 1'b0;
      #1;
      check_output("async reset x5", rd(0), 32'h0);
      check_output("async reset x12", rd(1), 32'h0);
      check_output("async reset hazard", 32'(bus.hazard), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_idle();
      set_rd(0, 5, 1'b0);
      set_rd(1, 12, 1'b0);
      apply_stimulus();
      check_output("after reset x5", rd(0), 32'h0);
      check_output("after reset x12 discarded", rd(1), 32'h0);
      next_edge();
      set_rd(0, 7, 1'b0);
      apply_stimulus();
      check_output("after reset x7", rd(0), 32'h0);
      next_edge();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the ID-stage integer register file.
- Provides a configurable number of combinational read ports and write ports, plus same-cycle write-to-read bypass.
- An internal scoreboard tracks registers with in-flight writes and raises a decode hazard signal.
- Sits in ID. Writeback ports come from WB and any secondary writeback (e.g. a multi-cycle unit). The issue port comes from the ID/EX handoff.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(NREG), register address width; derived, not overridden.
- NRD, 2, number of read ports; 1..4.
- NWR, 2, number of write ports; 1..4.

Ports:
- clk_cpu  input  1  CPU clock; all state updates on the rising edge.
- rst_cpu_n  input  1  asynchronous, active-low reset.
- rd_addr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_used  input  NRD  port k's operand is consumed by the decoding instruction.
- rd_data  output  NRD*XLEN  read data per port, after bypass.
- rd_pend  output  NRD  port k's source register has an unresolved pending write.
- wr_en  input  NWR  write enable per write port.
- wr_addr  input  NWR*AW  write addresses.
- wr_data  input  NWR*XLEN  write data.
- iss_valid  input  1  an instruction that writes iss_rd leaves ID this cycle.
- iss_rd  input  AW  destination register of the issuing instruction.
- flush  input  1  pipeline flush; clears all pending bits.
- hazard  output  1  decode must stall.
- pend_cnt  output  AW+1  number of registers currently marked pending.

Behaviour:
- Storage: NREG x XLEN array plus an NREG-bit pending vector.
  - Register 0 always reads 0; writes to it are discarded; its pending bit is never set.
- Reset (rst_cpu_n low, asynchronous): all registers cleared to 0, pending vector cleared, pend_cnt = 0.
  - Outputs are combinational from state, so while in reset: rd_data = 0 for all ports, rd_pend = 0, hazard = 0.
  - Reset asserted mid-operation discards any write or issue in that cycle.
- Write: on the rising edge, for each port j with wr_en[j]=1 and wr_addr[j]!=0, the register is updated with wr_data[j].
  - If several ports target the same address in one cycle, the highest port index wins.
- Read: combinational, zero cycles of latency.
  - rd_data[k] = 0 if rd_addr[k]==0.
  - Otherwise, if any port j has wr_en[j]=1 and wr_addr[j]==rd_addr[k] in the same cycle, rd_data[k] = wr_data of the highest such j (bypass).
  - Otherwise rd_data[k] = the stored value.
- Scoreboard, evaluated per rising edge, each step overriding the previous:
  1. Every register written (wr_en, addr != 0) has its pending bit cleared.
  2. If iss_valid=1 and iss_rd!=0, pending[iss_rd] is set. Set beats a clear of the same register in the same cycle, because the issuing instruction is younger.
  3. If flush=1, the whole pending vector is cleared. Flush beats both set and clear; the register writes themselves still occur.
- rd_pend[k] = pending[rd_addr[k]] AND NOT (same-cycle bypass hit on rd_addr[k]). A register being written this cycle is not pending to readers.
- hazard = OR over k of (rd_used[k] AND rd_pend[k]), OR (iss_valid AND iss_rd!=0 AND pending[iss_rd] AND no same-cycle write to iss_rd).
  - The second term is the WAW stall.
  - When hazard=1, the upstream keeps iss_valid low; the block does not gate iss_valid internally.
- pend_cnt: registered population count of the pending vector, equal to the count after that edge's update. Range 0..NREG-1.
- Clearing a pending bit that is not set has no effect. Setting one that is already set has no effect (no counting per register).

Test Plan:
- Reset, then read addresses 0..31 on all ports -> every rd_data = 0, hazard = 0, pend_cnt = 0.
- Write x5=0xDEADBEEF on port 0 while reading x5 the same cycle -> rd_data = 0xDEADBEEF in that cycle (bypass). Next cycle with wr_en=0 -> still 0xDEADBEEF.
- Ports 0 and 1 both write x7 (0x11, 0x22) in one cycle -> x7 reads 0x22, both same-cycle and afterwards. Writes to x0 of 0xFFFFFFFF -> x0 reads 0.
- Issue x3 -> pend_cnt = 1. Read x3 with rd_used=1 -> hazard = 1.
  - WB writes x3=0x40 -> same cycle rd_pend = 0, hazard = 0, rd_data = 0x40. Next cycle pend_cnt = 0.
- Same cycle: writeback clears x9 and an issue sets x9 -> x9 remains pending (pend_cnt unchanged).
  - Issue x9 again while it is pending with no write -> hazard = 1 (WAW).
- Pend x1, x2, x4, then assert flush together with iss_valid on x6 -> pend_cnt = 0 next cycle.
  - Then drop rst_cpu_n mid-cycle with writes active -> registers read 0 immediately.
